pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001: Parameter DATA_W, default 32, SHALL set the width of the datapath payload (e.g. ALU result plus store data).
REQ-002: Parameter CTRL_W, default 4, SHALL set the width of the control payload (e.g. MemWrite, MemRead, C_EN, spare).
REQ-003: Parameter BCNT_W, default 16, SHALL set the width of the bubble counter.
REQ-004: Clk  input  1  SHALL be the single clock; all state updates SHALL occur on posedge Clk.
REQ-005: Reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006: flush  input  1  SHALL be a synchronous discard of all held entries.
REQ-007: in_valid  input  1  SHALL indicate that the upstream stage offers an entry.
REQ-008: in_ctrl  input  CTRL_W  SHALL carry the offered control bits.
REQ-009: in_data  input  DATA_W  SHALL carry the offered data.
REQ-010: in_ready  output  1  SHALL indicate that the stage accepts an entry this cycle; it SHALL be a registered signal.
REQ-011: out_valid  output  1  SHALL indicate that out_ctrl/out_data hold a valid entry.
REQ-012: out_ready  input  1  SHALL indicate that the downstream stage consumes the entry this cycle.
REQ-013: out_ctrl  output  CTRL_W  SHALL carry the control bits of the head entry.
REQ-014: out_data  output  DATA_W  SHALL carry the data of the head entry.
REQ-015: bubble_cnt  output  BCNT_W  SHALL count cycles in which downstream was ready but no entry was valid.

Function
REQ-016: Input transfer SHALL occur when in_valid=1 and in_ready=1; output transfer SHALL occur when out_valid=1 and out_ready=1.
REQ-017: Storage SHALL be a main register driving the outputs plus a one-entry skid register; states SHALL be EMPTY, ONE (main only) and TWO (main + skid).
REQ-018: EMPTY: on input transfer, main<=input and state->ONE; otherwise state holds.
REQ-019: ONE, input only: skid<=input and state->TWO; output only: state->EMPTY; both: main<=input and state stays ONE; neither: state holds.
REQ-020: TWO: on output transfer, main<=skid and state->ONE; no input transfer SHALL occur in TWO.
REQ-021: in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO, decoded from the registered state.
REQ-022: out_valid SHALL be 1 in ONE and TWO.
REQ-023: Latency from input transfer in EMPTY to out_valid=1 SHALL be exactly 1 cycle; sustained throughput SHALL be 1 entry/cycle with out_ready held at 1.
REQ-024: Entries SHALL leave in acceptance order; no entry SHALL be dropped or duplicated except by flush.
REQ-025: out_ctrl SHALL be all zeros whenever out_valid=0 (bubble carries no MemWrite/MemRead); out_data MAY hold its last value.
REQ-026: out_ctrl/out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027: flush=1 SHALL have highest priority: state->EMPTY next cycle, an input transfer in the same cycle SHALL be discarded, and any output transfer that cycle SHALL still count as consumed.
REQ-028: bubble_cnt SHALL increment by 1 each cycle with out_ready=1 and out_valid=0, and SHALL saturate at 2^BCNT_W-1 without wrapping.

Reset
REQ-029: While Reset=1 and immediately after it deasserts: state=EMPTY, in_ready=1, out_valid=0, out_ctrl=0, out_data=0, skid=0, bubble_cnt=0.
REQ-030: Reset asserted mid-operation SHALL discard all entries asynchronously with no partial transfer completing.

Verification
REQ-031: Reset, then in_valid=1, in_ctrl=4'b0010, in_data=0x1234, out_ready=1 for one cycle -> next cycle out_valid=1, out_ctrl=4'b0010, out_data=0x1234; following cycle out_valid=0, out_ctrl=0.
REQ-032: out_ready=0; push 0xA then 0xB -> in_ready=0 after second push; raise out_ready -> 0xA then 0xB on consecutive cycles, in_ready returns to 1.
REQ-033: Stream 0x1..0x10 with in_valid=1, out_ready=1 -> 16 consecutive output transfers in order, in_ready stays 1.
REQ-034: State TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_ctrl=0, offered entry absent from output.
REQ-035: BCNT_W=2, out_ready=1, no input for 5 cycles -> bubble_cnt 1,2,3,3,3.
REQ-036: Assert Reset in state TWO -> out_valid=0, in_ready=1, bubble_cnt=0 without waiting for a Clk edge.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage with a main output register and a one-entry skid buffer.
// in_ready depends only on registered state, so the ready path is broken at this stage.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int BCNT_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [BCNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              in_xfer;
    logic              out_xfer;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // A bubble must never carry MemWrite/MemRead downstream.
    assign out_ctrl   = out_valid ? main_ctrl_q : '0;
    assign out_data   = main_data_q;
    assign bubble_cnt = bcnt_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                    state_d     = ONE;
                end
            end
            ONE: begin
                case ({in_xfer, out_xfer})
                    2'b10: begin
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                        state_d     = TWO;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                    default: ;
                endcase
            end
            TWO: begin
                if (out_xfer) begin
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush wins: held entries and any same-cycle input are discarded.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        bcnt_d = bcnt_q;
        if (out_ready && !out_valid && (bcnt_q != {BCNT_W{1'b1}})) begin
            bcnt_d = bcnt_q + {{(BCNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= EMPTY;
            // NOTE: storage is reset too, because out_data and the skid entry must read zero after reset.
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            bcnt_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            bcnt_q      <= bcnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a queue of accepted entries is the reference model.
module tb_pipe_stage_skid;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_ready = 1'b0;

    logic              in_ready, out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       bubble_cnt;

    logic              b_in_ready, b_out_valid;
    logic [CTRL_W-1:0] b_out_ctrl;
    logic [DATA_W-1:0] b_out_data;
    logic [1:0]        b_bubble_cnt;

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .BCNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .flush(flush),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .bubble_cnt(bubble_cnt)
    );

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .BCNT_W(2)) dut_b (
        .Clk(Clk), .Reset(Reset), .flush(flush),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .bubble_cnt(b_bubble_cnt)
    );

    always #5 Clk = ~Clk;

    int     total = 0;
    int     bad = 0;
    int     pops = 0;
    longint bub_model = 0;
    entry_t exp_q[$];
    logic   exp_v, exp_r;
    entry_t exp_head;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint sat(input longint v, input longint m);
        return (v > m) ? m : v;
    endfunction

    task automatic check_view(input string tag, input logic v, input logic r,
                              input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        check({tag, " out_valid"}, v, exp_v);
        check({tag, " in_ready"}, r, exp_r);
        if (exp_v) begin
            check({tag, " out_ctrl"}, c, exp_head.ctrl);
            check({tag, " out_data"}, d, exp_head.data);
        end else begin
            check({tag, " bubble out_ctrl"}, c, 0);
        end
    endtask

    // Monitor: compares the visible head against the model and retires consumed entries.
    always @(negedge Clk) begin
        if (!Reset) begin
            exp_v    = (exp_q.size() != 0);
            exp_r    = (exp_q.size() < 2);
            exp_head = exp_v ? exp_q[0] : '0;
            check_view("a", out_valid, in_ready, out_ctrl, out_data);
            check_view("b", b_out_valid, b_in_ready, b_out_ctrl, b_out_data);
            check("a bubble_cnt", bubble_cnt, sat(bub_model, 65535));
            check("b bubble_cnt", b_bubble_cnt, sat(bub_model, 3));
            if (out_ready && !exp_v) bub_model++;
            if (out_ready && exp_v) begin
                void'(exp_q.pop_front());
                pops++;
            end
            if (flush) exp_q.delete();
        end
    end

    // One cycle of stimulus; the accepted entry is recorded after the monitor has sampled.
    task automatic step();
        @(negedge Clk);
        #1;
        if (!Reset && in_valid && exp_r && !flush)
            exp_q.push_back(entry_t'{ctrl: in_ctrl, data: in_data});
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        exp_q.delete();
        bub_model = 0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst out_valid", out_valid, 0);
        check("rst in_ready", in_ready, 1);
        check("rst out_ctrl", out_ctrl, 0);
        check("rst out_data", out_data, 0);
        check("rst bubble_cnt", bubble_cnt, 0);
        check("rst b bubble_cnt", b_bubble_cnt, 0);
        @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    task automatic push(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    logic [1:0] bub_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    int         pops_before;

    initial begin
        #1;
        do_reset();

        // Single entry: visible one cycle after acceptance, then a clean bubble.
        out_ready = 1'b1;
        push(4'b0010, 32'h1234);
        repeat (3) step();

        // Stall fills the skid, then both drain in order.
        out_ready = 1'b0;
        push(4'h1, 32'hA);
        push(4'h2, 32'hB);
        step();
        out_ready = 1'b1;
        repeat (3) step();

        // Back-to-back stream at full rate.
        pops_before = pops;
        in_valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_ctrl = CTRL_W'(i);
            in_data = DATA_W'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        check("stream transfer count", pops - pops_before, 16);

        // Flush while full, with an offered entry.
        out_ready = 1'b0;
        push(4'h4, 32'h111);
        push(4'h8, 32'h222);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 4'hF;
        in_data  = 32'hDEAD;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // Flush while holding one entry, offered entry would otherwise be accepted.
        push(4'h3, 32'h333);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hBEEF;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (2) step();

        // Bubble counter saturation in the narrow instance.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("b bubble seq", b_bubble_cnt, bub_seq[i]);
        end

        // Asynchronous reset while full.
        out_ready = 1'b0;
        push(4'h5, 32'h555);
        push(4'h6, 32'h666);
        #2 Reset = 1'b1;
        #1;
        check("async rst out_valid", out_valid, 0);
        check("async rst in_ready", in_ready, 1);
        check("async rst out_ctrl", out_ctrl, 0);
        check("async rst bubble_cnt", bubble_cnt, 0);
        check("async rst b bubble_cnt", b_bubble_cnt, 0);
        do_reset();

        // Randomized traffic with varying downstream back-pressure.
        for (int phase = 0; phase < 4; phase++) begin
            for (int n = 0; n < 700; n++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_ctrl   = CTRL_W'($urandom);
                in_data   = $urandom;
                out_ready = ($urandom_range(0, 3) < phase + 1);
                flush     = ($urandom_range(0, 63) == 0);
                step();
            end
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("drained model depth", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
